// File: rtl/pwr_sched_pkg.sv
// Shared types and sizing helpers for the power-gating scheduler.
// The package is not parameterised, so the widths are supplied as constant functions.
package pwr_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ISO  = 2'd1,
        S_OFF  = 2'd2,
        S_WAKE = 2'd3
    } state_t;

    // Width of an index over n peripherals. It is never less than 1, so that N=1 still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // CNT_W: width of the settle counter, enough to hold the value SETTLE.
    function automatic int cnt_width(input int settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/pwr_rr_arbiter.sv
// Combinational round-robin pick. The search starts at ptr and wraps modulo N.
// The top uses one instance for wake requests and one for gate requests.
module pwr_rr_arbiter
    import pwr_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N) ? s - N : s;
    endfunction

    // The scan runs from the farthest offset down, so the request nearest ptr is written last and wins.
    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req[wrap_idx(int'(ptr), off)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(wrap_idx(int'(ptr), off));
            end
        end
    end

endmodule

// File: rtl/pwr_gate_scheduler.sv
// Per-peripheral power-gating scheduler. One shared sequencer drives isolation and the power switch
// for a single peripheral at a time. Wake requests take priority over gate requests.
module pwr_gate_scheduler
    import pwr_sched_pkg::*;
#(
    parameter int N      = 4,
    parameter int W      = 16,
    parameter int SETTLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        periph_en,
    input  logic [N-1:0][W-1:0] idle_count,
    input  logic [N-1:0]        recent_activity,
    input  logic [W-1:0]        idle_thresh,
    input  logic [N-1:0]        wake_req,
    output logic [N-1:0]        iso_en,
    output logic [N-1:0]        pwr_off,
    output logic [N-1:0]        gated,
    output logic [N-1:0]        wake_done,
    output logic                sched_busy
);

    localparam int IDX_W = idx_width(N);
    localparam int CNT_W = cnt_width(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0] gnt_k, gnt_k_d;
    logic [N-1:0]     iso_d, pwr_d, gated_d, wake_done_d;

    logic [N-1:0]     gate_cand, wake_cand;
    logic             wake_valid, gate_valid;
    logic [IDX_W-1:0] wake_idx, gate_idx;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            gate_cand[i] = periph_en[i] & ~gated[i] & ~recent_activity[i] & ~wake_req[i]
                         & (idle_thresh != '0) & (idle_count[i] >= idle_thresh);
        end
    end

    // A gated peripheral can always be woken, whether or not it is still enabled.
    assign wake_cand = gated & wake_req;

    pwr_rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_wake_arb (
        .req       (wake_cand),
        .ptr       (rr_ptr),
        .gnt_valid (wake_valid),
        .gnt_idx   (wake_idx)
    );

    pwr_rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_gate_arb (
        .req       (gate_cand),
        .ptr       (rr_ptr),
        .gnt_valid (gate_valid),
        .gnt_idx   (gate_idx)
    );

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] k);
        return (int'(k) == N - 1) ? '0 : k + 1'b1;
    endfunction

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rr_ptr_d    = rr_ptr;
        gnt_k_d     = gnt_k;
        iso_d       = iso_en;
        pwr_d       = pwr_off;
        gated_d     = gated;
        wake_done_d = '0;

        case (state)
            S_IDLE: begin
                if (wake_valid) begin
                    gnt_k_d         = wake_idx;
                    pwr_d[wake_idx] = 1'b0;
                    cnt_d           = CNT_LOAD;
                    rr_ptr_d        = ptr_after(wake_idx);
                    state_d         = S_WAKE;
                end else if (gate_valid) begin
                    gnt_k_d         = gate_idx;
                    iso_d[gate_idx] = 1'b1;
                    cnt_d           = CNT_LOAD;
                    rr_ptr_d        = ptr_after(gate_idx);
                    state_d         = S_ISO;
                end
            end
            S_ISO: begin
                if (cnt == '0) begin
                    pwr_d[gnt_k] = 1'b1;
                    cnt_d        = CNT_LOAD;
                    state_d      = S_OFF;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_OFF: begin
                if (cnt == '0) begin
                    gated_d[gnt_k] = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_WAKE: begin
                if (cnt == '0) begin
                    iso_d[gnt_k]       = 1'b0;
                    gated_d[gnt_k]     = 1'b0;
                    wake_done_d[gnt_k] = 1'b1;
                    state_d            = S_IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset can arrive in the middle of a sequence. It drops that sequence and leaves every peripheral powered and un-isolated.
    // NOTE: state is updated with non-blocking assignments, so each register loads its next value at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            gnt_k     <= '0;
            iso_en    <= '0;
            pwr_off   <= '0;
            gated     <= '0;
            wake_done <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rr_ptr    <= rr_ptr_d;
            gnt_k     <= gnt_k_d;
            iso_en    <= iso_d;
            pwr_off   <= pwr_d;
            gated     <= gated_d;
            wake_done <= wake_done_d;
        end
    end

    assign sched_busy = (state != S_IDLE);

endmodule
